ram_bridge: RTL and testbench

Sequencing bridge between the processor controller and a 1024-word synchronous RAM; it sits directly downstream of the controller's `RAM_read_from_RAM` and `RAM_write_to_RAM` outputs. It latches addresses and data from the shared data bus and runs the RAM access handshake. For loads, it stalls the timestep counter until RAM data is ready, then drives that data onto the shared bus for one cycle.

---
 rtl/ram_bridge_pkg.sv | 17 +
 rtl/ram_bridge.sv | 135 +++++++++++++
 tb/tb_ram_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bridge_pkg.sv
// Shared widths and FSM state type for the RAM sequencing bridge.
// Imported by the controller-facing top level so both sides agree on bus width.
package ram_bridge_pkg;

  localparam int RAM_DATA_W         = 10;
  localparam int RAM_RD_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_DATA  = 3'd1,
    WRITE   = 3'd2,
    R_WAIT  = 3'd3,
    R_CAP   = 3'd4,
    R_DRIVE = 3'd5
  } ram_bridge_state_t;

endpackage

// File: rtl/ram_bridge.sv
// Bridge between the processor controller and a synchronous RAM: latches address/data
// from the shared bus, stalls the timestep counter on loads and drives read data back.
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int DATA_W     = RAM_DATA_W,
  parameter int RD_LATENCY = RAM_RD_LATENCY_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RAM_read_from_RAM,
  input  logic              RAM_write_to_RAM,
  input  logic [DATA_W-1:0] Bus,
  output logic [DATA_W-1:0] BusOut,
  output logic              BusOutEn,
  output logic              Stall,
  output logic              Err,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                CNT_W    = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  ram_bridge_state_t state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] data_q, data_next;
  logic [DATA_W-1:0] rd_q, rd_next;

  logic stall_c;
  logic err_c;
  logic we_c;
  logic oe_c;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_q    <= addr_next;
      data_q    <= data_next;
      rd_q      <= rd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_q;
    data_next  = data_q;
    rd_next    = rd_q;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    we_c       = 1'b0;
    oe_c       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RAM_read_from_RAM) begin
          addr_next  = Bus;
          cnt_next   = CNT_LOAD;
          state_next = R_WAIT;
          stall_c    = 1'b1;
          err_c      = RAM_write_to_RAM;
        end else if (RAM_write_to_RAM) begin
          addr_next  = Bus;
          state_next = W_DATA;
        end
      end

      W_DATA: begin
        // A load arriving mid-store abandons the store and restarts as a fresh read.
        if (RAM_read_from_RAM) begin
          addr_next  = Bus;
          cnt_next   = CNT_LOAD;
          state_next = R_WAIT;
          stall_c    = 1'b1;
          err_c      = 1'b1;
        end else if (RAM_write_to_RAM) begin
          data_next  = Bus;
          state_next = WRITE;
          stall_c    = 1'b1;
        end
      end

      WRITE: begin
        we_c       = 1'b1;
        state_next = IDLE;
      end

      R_WAIT: begin
        stall_c = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = R_CAP;
        end else begin
          cnt_next = cnt_reg - CNT_LAST;
        end
      end

      R_CAP: begin
        stall_c    = 1'b1;
        rd_next    = ram_rdata;
        state_next = R_DRIVE;
      end

      R_DRIVE: begin
        oe_c       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while Reset is high so an aborted store never strobes the RAM.
  assign Stall     = stall_c & ~Reset;
  assign Err       = err_c & ~Reset;
  assign ram_we    = we_c & ~Reset;
  assign BusOutEn  = oe_c & ~Reset;
  assign BusOut    = BusOutEn ? rd_q : '0;
  assign ram_addr  = addr_q;
  assign ram_wdata = data_q;

endmodule

// File: tb/tb_ram_bridge.sv
// Directed plus randomized transaction bench for ram_bridge, checked against a
// word-level memory model and the cycle counts of the load/store handshakes.
module tb_ram_bridge;

  localparam int W   = 10;
  localparam int LAT = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         rd, wr;
  logic [W-1:0] bus;
  logic [W-1:0] busout, ram_addr, ram_wdata, ram_rdata;
  logic         oe, stall, err, ram_we;

  logic         rd1;
  logic [W-1:0] bus1;
  logic [W-1:0] busout1, ram_addr1, ram_wdata1, ram_rdata1;
  logic         oe1, stall1, err1, ram_we1;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic mem_load;

  logic [W-1:0] model   [1024];
  logic [W-1:0] env_mem [1024];
  logic [W-1:0] pipe    [LAT];
  logic [W-1:0] pipe1;

  ram_bridge #(.DATA_W(W), .RD_LATENCY(LAT)) dut (
    .Clock(clock), .Reset(reset),
    .RAM_read_from_RAM(rd), .RAM_write_to_RAM(wr), .Bus(bus),
    .BusOut(busout), .BusOutEn(oe), .Stall(stall), .Err(err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  ram_bridge #(.DATA_W(W), .RD_LATENCY(1)) dut1 (
    .Clock(clock), .Reset(reset),
    .RAM_read_from_RAM(rd1), .RAM_write_to_RAM(1'b0), .Bus(bus1),
    .BusOut(busout1), .BusOutEn(oe1), .Stall(stall1), .Err(err1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1)
  );

  // Behavioural RAM: read data appears LAT cycles after the address is presented.
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= model[i];
    end else if (ram_we) begin
      env_mem[ram_addr] <= ram_wdata;
      we_count <= we_count + 1;
    end
    pipe[0] <= env_mem[ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    pipe1 <= env_mem[ram_addr1];
  end
  assign ram_rdata  = pipe[LAT-1];
  assign ram_rdata1 = pipe1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic w, input logic [W-1:0] b);
    @(negedge clock);
    rd = r; wr = w; bus = b;
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, 1023));
  endfunction

  task automatic do_read(input logic [W-1:0] a, input logic also_wr, input logic exp_err);
    logic [W-1:0] exp_d;
    exp_d = model[a];
    tick(1'b1, also_wr, a);
    chk("rd_req_stall", stall, 1);
    chk("rd_req_err", err, exp_err);
    chk("rd_req_oe", oe, 0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(1'b0, 1'b0, rnd());
      chk("rd_wait_stall", stall, 1);
      chk("rd_wait_oe", oe, 0);
      chk("rd_wait_err", err, 0);
      chk("rd_wait_addr", ram_addr, a);
      chk("rd_wait_we", ram_we, 0);
    end
    tick(1'b0, 1'b0, rnd());
    chk("rd_drive_stall", stall, 0);
    chk("rd_drive_oe", oe, 1);
    chk("rd_drive_data", busout, exp_d);
    $display("read  addr=%h data=%h err=%0d", a, busout, exp_err);
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d, input int gap);
    tick(1'b0, 1'b1, a);
    chk("wr_addr_stall", stall, 0);
    chk("wr_addr_err", err, 0);
    for (int g = 0; g < gap; g++) begin
      tick(1'b0, 1'b0, rnd());
      chk("wr_hold_stall", stall, 0);
      chk("wr_hold_we", ram_we, 0);
    end
    tick(1'b0, 1'b1, d);
    chk("wr_data_stall", stall, 1);
    chk("wr_data_we", ram_we, 0);
    tick(1'b0, 1'b0, rnd());
    chk("wr_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, a);
    chk("wr_ram_wdata", ram_wdata, d);
    chk("wr_we_stall", stall, 0);
    model[a] = d;
    $display("write addr=%h data=%h gap=%0d", a, d, gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int we_before;
    logic [W-1:0] a;

    for (int i = 0; i < 1024; i++) model[i] = rnd();
    model[10'h2A5] = 10'h1F3;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; bus = '0; rd1 = 1'b0; bus1 = '0;
    mem_load = 1'b1;
    repeat (3) @(negedge clock);
    mem_load = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, '0);
      chk("rst_stall", stall, 0);
      chk("rst_oe", oe, 0);
      chk("rst_busout", busout, 0);
      chk("rst_err", err, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
    end
    chk("rst_we_count", 16'(we_count), 0);

    do_read(10'h2A5, 1'b0, 1'b0);
    do_write(10'h3FF, 10'h155, 1);
    do_read(10'h3FF, 1'b0, 1'b0);

    we_before = we_count;
    do_read(10'h004, 1'b1, 1'b1);
    tick(1'b0, 1'b0, '0);
    chk("rdwr_no_we", ram_we, 0);
    chk("rdwr_we_count", 16'(we_count), 16'(we_before));

    we_before = we_count;
    tick(1'b0, 1'b1, 10'h0AA);
    chk("abort_addr_stall", stall, 0);
    do_read(10'h123, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, rnd());
      chk("abort_no_we", ram_we, 0);
    end
    chk("abort_we_count", 16'(we_count), 16'(we_before));

    we_before = we_count;
    tick(1'b1, 1'b0, 10'h2A5);
    tick(1'b0, 1'b0, '0);
    chk("rst_mid_wait_stall", stall, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_oe", oe, 0);
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1'b0, 1'b0, '0);
      chk("rst_mid_idle_oe", oe, 0);
      chk("rst_mid_idle_stall", stall, 0);
    end
    chk("rst_mid_we_count", 16'(we_count), 16'(we_before));
    $display("reset during read wait: aborted");

    // Latency-1 instance: request, wait, capture, drive -> four cycles total.
    a = 10'h3FF;
    @(negedge clock); rd1 = 1'b1; bus1 = a; #1;
    chk("l1_c0_stall", stall1, 1);
    @(negedge clock); rd1 = 1'b0; bus1 = rnd(); #1;
    chk("l1_c1_stall", stall1, 1);
    chk("l1_c1_addr", ram_addr1, a);
    @(negedge clock); #1;
    chk("l1_c2_stall", stall1, 1);
    chk("l1_c2_oe", oe1, 0);
    @(negedge clock); #1;
    chk("l1_c3_stall", stall1, 0);
    chk("l1_c3_oe", oe1, 1);
    chk("l1_c3_data", busout1, model[a]);
    chk("l1_we", ram_we1, 0);
    chk("l1_err", err1, 0);
    chk("l1_wdata", ram_wdata1, 0);
    $display("read  addr=%h data=%h latency=1", a, busout1);
    @(negedge clock); #1;
    chk("l1_c4_oe", oe1, 0);
    chk("l1_c4_busout", busout1, 0);

    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 3) == 0) ? rnd() : W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, rnd(), int'($urandom_range(0, 3)));
      else do_read(a, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
